// File: rtl/logic_op_arbiter_pkg.sv
// Shared definitions for the logic-op arbiter: default width, op codes and FSM states.
package logic_op_arbiter_pkg;

  localparam int unsigned WIDTH_DEFAULT = 24;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_ANDC = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/logic_op_arbiter_logic_unit.sv
// Combinational bitwise datapath: y = a <op> b over the full width, no carries.
module logic_unit
  import logic_op_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  input  logic [1:0]       op,
  output logic [0:WIDTH-1] y
);

  always_comb begin
    y = '0;
    unique case (op_e'(op))
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_ANDC: y = a & ~b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Two-requester round-robin arbiter feeding one shared logic unit; the result is
// registered and held until the consumer takes it.
module logic_op_arbiter
  import logic_op_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [0:WIDTH-1] req0_a,
  input  logic [0:WIDTH-1] req0_b,
  output logic             req0_ready,

  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [0:WIDTH-1] req1_a,
  input  logic [0:WIDTH-1] req1_b,
  output logic             req1_ready,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [0:WIDTH-1] rsp_y,
  output logic             rsp_zero
);

  state_e           state_q, state_d;
  logic             rr_ptr_q;
  logic             can_accept;
  logic             sel;
  logic             grant;
  logic [1:0]       mux_op;
  logic [0:WIDTH-1] mux_a;
  logic [0:WIDTH-1] mux_b;
  logic [0:WIDTH-1] unit_y;

  // Preferred requester wins on contention; a lone requester wins regardless.
  always_comb begin
    sel = req1_valid;
    if (req0_valid && req1_valid) begin
      sel = rr_ptr_q;
    end
  end

  // Reset gates acceptance so ready stays low while rst is held.
  assign can_accept = !rst && ((state_q == ST_IDLE) || rsp_ready);
  assign req0_ready = can_accept && req0_valid && !sel;
  assign req1_ready = can_accept && req1_valid && sel;
  assign grant      = req0_ready || req1_ready;

  assign mux_op = sel ? req1_op : req0_op;
  assign mux_a  = sel ? req1_a  : req0_a;
  assign mux_b  = sel ? req1_b  : req0_b;

  logic_unit #(
    .WIDTH (WIDTH)
  ) u_logic_unit (
    .a  (mux_a),
    .b  (mux_b),
    .op (mux_op),
    .y  (unit_y)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (grant) begin
          state_d = ST_HOLD;
        end else if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_y    <= '0;
      rsp_zero <= 1'b1;
    end else if (grant) begin
      rr_ptr_q <= ~sel;
      rsp_id   <= sel;
      rsp_y    <= unit_y;
      rsp_zero <= ~|unit_y;
    end
  end

  assign rsp_valid = (state_q == ST_HOLD);

endmodule
